// File: rtl/feature_map_serializer_pkg.sv
// feature_map_serializer_pkg: shared constants, state encoding and helpers
// for the pixel-vector to channel-word serializer.
package feature_map_serializer_pkg;

  localparam int DEF_DATA_WIDHT = 32;
  localparam int DEF_CHANNEL    = 128;
  localparam int DEF_IMG_WIDHT  = 44;
  localparam int DEF_IMG_HEIGHT = 44;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int FRAME_PIXELS = DEF_IMG_WIDHT * DEF_IMG_HEIGHT;
  localparam int CH_IDX_W     = $clog2(DEF_CHANNEL);
  localparam int PIX_CNT_W    = $clog2(FRAME_PIXELS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/feature_map_serializer_fifo.sv
// pixel_fifo: synchronous pixel-vector FIFO, push accepted when full if a
// pop happens on the same edge.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty, count.
module pixel_fifo
  import feature_map_serializer_pkg::*;
#(
  parameter int WIDTH = 4096,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/feature_map_serializer.sv
// feature_map_serializer: buffers wide pixel vectors and replays them as a
// valid/ready stream of channel words, channel 0 first, with pixel/frame tags.
// Ports: clk, rst (sync, active-high); Data_In/Valid_In pixel input;
// Word_Out/Word_Valid/Word_Ready word stream; Word_Last_Pixel,
// Word_Last_Frame tags; Overflow (sticky drop flag); Fifo_Count.
module feature_map_serializer
  import feature_map_serializer_pkg::*;
#(
  parameter int DATA_WIDHT = DEF_DATA_WIDHT,
  parameter int CHANNEL    = DEF_CHANNEL,
  parameter int IMG_WIDHT  = DEF_IMG_WIDHT,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
  input  logic                          Valid_In,
  output logic [DATA_WIDHT-1:0]         Word_Out,
  output logic                          Word_Valid,
  input  logic                          Word_Ready,
  output logic                          Word_Last_Pixel,
  output logic                          Word_Last_Frame,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  localparam int PW      = DATA_WIDHT * CHANNEL;
  localparam int FRAME_N = IMG_WIDHT * IMG_HEIGHT;
  localparam int CH_W    = clog2_min1(CHANNEL);
  localparam int PC_W    = clog2_min1(FRAME_N);

  ser_state_e      state;
  ser_state_e      state_nx;
  logic [PW-1:0]   sreg;
  logic [CH_W-1:0] ch;
  logic [PC_W-1:0] pix_cnt;

  logic [PW-1:0]   f_dout;
  logic            f_full;
  logic            f_empty;
  logic            xfer;
  logic            last_ch;
  logic            load;

  assign xfer    = (state == SEND) && Word_Ready;
  assign last_ch = (ch == CH_W'(CHANNEL - 1));
  // Next pixel is taken either from idle or back-to-back on the final word,
  // using only what the FIFO held before this edge.
  assign load    = !f_empty && ((state == IDLE) || (xfer && last_ch));

  pixel_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (Valid_In),
    .din   (Data_In),
    .pop   (load),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (Fifo_Count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!f_empty) state_nx = SEND;
      SEND:    if (xfer && last_ch && f_empty) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Word_Valid      = (state == SEND);
    Word_Last_Pixel = Word_Valid && last_ch;
    Word_Last_Frame = Word_Last_Pixel && (pix_cnt == PC_W'(FRAME_N - 1));
  end

  assign Word_Out = sreg[DATA_WIDHT-1:0];

  // Channel 0 sits in the low word; each transfer shifts the next one down.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      ch   <= '0;
    end else if (load) begin
      sreg <= f_dout;
      ch   <= '0;
    end else if (xfer) begin
      sreg <= sreg >> DATA_WIDHT;
      ch   <= last_ch ? '0 : ch + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (xfer && last_ch) begin
      pix_cnt <= (pix_cnt == PC_W'(FRAME_N - 1)) ? '0 : pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Overflow <= 1'b0;
    end else if (Valid_In && f_full && !load) begin
      Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_feature_map_serializer.sv
// tb_feature_map_serializer: directed stimulus with a scoreboard queue of
// expected words, checked by an independent negedge monitor.
module tb_feature_map_serializer;

  localparam int DW    = 32;
  localparam int CH    = 128;
  localparam int IW    = 4;
  localparam int IH    = 3;
  localparam int FD    = 4;
  localparam int FRAME = IW * IH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW*CH-1:0]  Data_In = '0;
  logic              Valid_In = 1'b0;
  logic [DW-1:0]     Word_Out;
  logic              Word_Valid;
  logic              Word_Ready = 1'b0;
  logic              Word_Last_Pixel;
  logic              Word_Last_Frame;
  logic              Overflow;
  logic [2:0]        Fifo_Count;

  feature_map_serializer #(
    .DATA_WIDHT (DW),
    .CHANNEL    (CH),
    .IMG_WIDHT  (IW),
    .IMG_HEIGHT (IH),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Data_In         (Data_In),
    .Valid_In        (Valid_In),
    .Word_Out        (Word_Out),
    .Word_Valid      (Word_Valid),
    .Word_Ready      (Word_Ready),
    .Word_Last_Pixel (Word_Last_Pixel),
    .Word_Last_Frame (Word_Last_Frame),
    .Overflow        (Overflow),
    .Fifo_Count      (Fifo_Count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          lp;
    logic          lf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   xfers = 0;
  int   lf_seen = 0;
  int   frame_pos = 0;
  logic rlevel = 1'b0;
  logic rpat = 1'b0;
  int   pcnt = 0;
  logic have_stall = 1'b0;
  logic [DW-1:0] h_d;
  logic h_lp;
  logic h_lf;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [DW*CH-1:0] mk(input logic [DW-1:0] base);
    logic [DW*CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  function automatic void enq(input logic [DW-1:0] base);
    exp_t x;
    for (int k = 0; k < CH; k++) begin
      x.d  = base + DW'(k);
      x.lp = (k == CH - 1);
      x.lf = (k == CH - 1) && (frame_pos == FRAME - 1);
      exp_q.push_back(x);
    end
    frame_pos = (frame_pos == FRAME - 1) ? 0 : frame_pos + 1;
  endfunction

  task automatic push(input logic [DW-1:0] base, input bit accept);
    Data_In  = mk(base);
    Valid_In = 1'b1;
    if (accept) enq(base);
    @(posedge clk);
    #1;
    Valid_In = 1'b0;
  endtask

  task automatic drain(output int bubbles);
    int n;
    bubbles = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (exp_q.size() != 0 && Word_Valid !== 1'b1) bubbles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    frame_pos = 0;
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rpat) begin
        Word_Ready = (pcnt % 4 == 0) || (pcnt % 4 == 3);
        pcnt++;
      end else begin
        Word_Ready = rlevel;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_stall = 1'b0;
      end else begin
        if (have_stall) begin
          checks++;
          if (Word_Valid !== 1'b1 || Word_Out !== h_d ||
              Word_Last_Pixel !== h_lp || Word_Last_Frame !== h_lf) begin
            errors++;
            $display("FAIL stall_hold: got v%b %h lp%b lf%b required v1 %h lp%b lf%b",
                     Word_Valid, Word_Out, Word_Last_Pixel, Word_Last_Frame,
                     h_d, h_lp, h_lf);
          end
        end
        if (Word_Valid === 1'b1 && Word_Ready === 1'b1) begin
          xfers++;
          if (Word_Last_Frame === 1'b1) lf_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h, required none", Word_Out);
          end else begin
            e = exp_q.pop_front();
            if ({Word_Out, Word_Last_Pixel, Word_Last_Frame} !==
                {e.d, e.lp, e.lf}) begin
              errors++;
              $display("FAIL word: got %h lp%b lf%b required %h lp%b lf%b",
                       Word_Out, Word_Last_Pixel, Word_Last_Frame,
                       e.d, e.lp, e.lf);
            end
          end
        end
        have_stall = (Word_Valid === 1'b1) && (Word_Ready === 1'b0);
        h_d  = Word_Out;
        h_lp = Word_Last_Pixel;
        h_lf = Word_Last_Frame;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int x0;
    int s0;
    int n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'({Word_Out, Word_Valid, Word_Last_Pixel,
        Word_Last_Frame, Overflow, Fifo_Count}), 64'd0);

    // Single pixel, ready always high
    @(posedge clk);
    #1;
    rlevel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(32'h1000_0000, 1'b1);
    @(negedge clk);
    chk("lat_count1", 64'({Fifo_Count, Word_Valid}), 64'({3'd1, 1'b0}));
    @(negedge clk);
    chk("lat_first", 64'({Fifo_Count, Word_Valid, Word_Out}),
        64'({3'd0, 1'b1, 32'h1000_0000}));
    @(posedge clk);
    #1;
    drain(b);
    chk("t1_bubbles", 64'(b), 64'd0);
    chk("t1_idle", 64'(Word_Valid), 64'd0);

    // Same pixel under a 1,0,0,1 ready pattern
    x0 = xfers;
    pcnt = 0;
    rpat = 1'b1;
    push(32'h1000_0000, 1'b1);
    drain(b);
    rpat = 1'b0;
    rlevel = 1'b1;
    chk("t2_words", 64'(xfers - x0), 64'd128);
    chk("t2_ovf", 64'(Overflow), 64'd0);

    // Fill with ready low, then overflow
    rlevel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) push(32'h2000_0000 + 32'(p << 8), 1'b1);
    chk("t3_full", 64'({Fifo_Count, Overflow, Word_Valid, Word_Out}),
        64'({3'd4, 1'b0, 1'b1, 32'h2000_0000}));
    push(32'h2000_0500, 1'b0);
    chk("t3_drop", 64'({Fifo_Count, Overflow}), 64'({3'd4, 1'b1}));
    x0 = xfers;
    rlevel = 1'b1;
    drain(b);
    chk("t3_bubbles", 64'(b), 64'd0);
    chk("t3_words", 64'(xfers - x0), 64'd640);
    chk("t3_ovf_sticky", 64'(Overflow), 64'd1);

    // Reset mid-pixel with two pixels queued
    for (int p = 0; p < 3; p++) push(32'h3000_0000 + 32'(p << 8), 1'b1);
    repeat (58) @(posedge clk);
    #1;
    chk("t5_queued", 64'(Fifo_Count), 64'd2);
    do_reset();
    chk("t5_after_rst", 64'({Word_Valid, Fifo_Count, Overflow}), 64'd0);
    push(32'h5000_0000, 1'b1);
    drain(b);
    chk("t5_ovf", 64'(Overflow), 64'd0);

    // Two full frames, paced
    do_reset();
    s0 = lf_seen;
    for (int i = 0; i < 2 * FRAME; i++) begin
      push(32'h6000_0000 + 32'(i << 8), 1'b1);
      repeat (129) @(posedge clk);
      #1;
    end
    drain(b);
    chk("t4_last_frames", 64'(lf_seen - s0), 64'd2);

    // Push into a full FIFO on the final-word edge
    rlevel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) push(32'h7000_0000 + 32'(p << 8), 1'b1);
    chk("t6_full", 64'(Fifo_Count), 64'd4);
    rlevel = 1'b1;
    n = 0;
    while (!(Word_Last_Pixel === 1'b1 && Word_Ready === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_last", 64'(n < 400), 64'd1);
    if (n < 400) begin
      Data_In  = mk(32'h7000_0500);
      Valid_In = 1'b1;
      enq(32'h7000_0500);
      @(posedge clk);
      #1;
      Valid_In = 1'b0;
      chk("t6_push", 64'({Fifo_Count, Overflow}), 64'({3'd4, 1'b0}));
    end
    drain(b);
    chk("t6_bubbles", 64'(b), 64'd0);
    chk("t6_ovf", 64'(Overflow), 64'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", 64'({Word_Valid, Fifo_Count}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
